// File: rtl/vga_port_arbiter_pkg.sv
// Shared types and default constants for the VGA text-card port arbiter.
// Used by vga_port_arbiter and rr_arbiter2.
package vga_arb_pkg;

    localparam int unsigned DEF_ADDR_W     = 12;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_CELLS      = 2400;
    localparam logic [15:0] DEF_CLEAR_WORD = 16'h0020;

    // Requester indices, also the encoding of the registered port owner
    localparam logic REQ_0 = 1'b0;
    localparam logic REQ_1 = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RWAIT,
        ST_ACK,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/vga_port_arbiter_rr_arbiter2.sv
// Two-way round-robin picker: combinational grant from req and pointer,
// pointer moves away from the winner whenever i_advance is high.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    logic r_ptr;

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves o_grant unassigned (no latch)
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= 1'b0;
        end else if (i_advance) begin
            r_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/vga_port_arbiter.sv
// Round-robin arbiter for the single VGA text-card port with req/ack per requester.
// Define VGA_ARB_CLEAR_EN to build in the screen-clear sequencer.
module vga_port_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned ADDR_W            = DEF_ADDR_W,
    parameter int unsigned DATA_W            = DEF_DATA_W,
    parameter int unsigned CELLS             = DEF_CELLS,
    parameter logic [DATA_W-1:0] CLEAR_WORD  = DATA_W'(DEF_CLEAR_WORD),
    parameter int unsigned RD_LAT            = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wd,
    output logic              r0_ack,
    output logic [DATA_W-1:0] r0_rd,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wd,
    output logic              r1_ack,
    output logic [DATA_W-1:0] r1_rd,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              vga_we,
    output logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_wd,
    input  logic [DATA_W-1:0] vga_rd
);

    state_t            r_state;
    logic              r_owner;
    logic              r_we_own;
    logic              r_ack0;
    logic              r_ack1;
    logic [DATA_W-1:0] r_rd0;
    logic [DATA_W-1:0] r_rd1;
    logic              r_vga_we;
    logic [ADDR_W-1:0] r_vga_addr;
    logic [DATA_W-1:0] r_vga_wd;

    logic [1:0]        w_grant;
    logic              w_clr_pend;
    logic              w_advance;
    logic              w_done;

`ifdef VGA_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CELLS - 1);

    logic              r_clr_pend;
    logic              r_clr_busy;
    logic [ADDR_W-1:0] r_clr_cnt;

    // Busy rises the cycle after clr_start and stays up until the last cell is written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clr_pend <= 1'b0;
            r_clr_busy <= 1'b0;
            r_clr_cnt  <= '0;
        end else begin
            if (r_state == ST_CLEAR) begin
                if (r_clr_cnt == CLR_LAST) begin
                    r_clr_cnt  <= '0;
                    r_clr_busy <= 1'b0;
                end else begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                end
            end else if (r_state == ST_IDLE && r_clr_pend) begin
                r_clr_pend <= 1'b0;
            end
            if (clr_start && !r_clr_busy) begin
                r_clr_pend <= 1'b1;
                r_clr_busy <= 1'b1;
            end
        end
    end

    assign w_clr_pend = r_clr_pend;
    assign clr_busy   = r_clr_busy;
`else
    wire w_unused_clr = clr_start | (CELLS == 0) | (|CLEAR_WORD);

    assign w_clr_pend = 1'b0;
    assign clr_busy   = 1'b0;
`endif

    assign w_advance = (r_state == ST_IDLE) && !w_clr_pend && (r0_req || r1_req);

    rr_arbiter2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_req     ({r1_req, r0_req}),
        .i_advance (w_advance),
        .o_grant   (w_grant)
    );

    // The access completes at the end of ISSUE for writes and zero-latency reads, else after RWAIT
    assign w_done = ((r_state == ST_ISSUE) && (r_we_own || RD_LAT == 0)) ||
                    (r_state == ST_RWAIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= REQ_0;
            r_we_own   <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_rd0      <= '0;
            r_rd1      <= '0;
            r_vga_we   <= 1'b0;
            r_vga_addr <= '0;
            r_vga_wd   <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;

            case (r_state)
                ST_IDLE: begin
`ifdef VGA_ARB_CLEAR_EN
                    if (r_clr_pend) begin
                        r_state    <= ST_CLEAR;
                        r_vga_we   <= 1'b1;
                        r_vga_addr <= '0;
                        r_vga_wd   <= CLEAR_WORD;
                    end else
`endif
                    if (|w_grant) begin
                        r_owner    <= w_grant[REQ_1] ? REQ_1 : REQ_0;
                        r_we_own   <= w_grant[REQ_1] ? r1_we   : r0_we;
                        r_vga_we   <= w_grant[REQ_1] ? r1_we   : r0_we;
                        r_vga_addr <= w_grant[REQ_1] ? r1_addr : r0_addr;
                        r_vga_wd   <= w_grant[REQ_1] ? r1_wd   : r0_wd;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_vga_we <= 1'b0;
                    r_state  <= (r_we_own || RD_LAT == 0) ? ST_ACK : ST_RWAIT;
                end
                ST_RWAIT: r_state <= ST_ACK;
                ST_ACK:   r_state <= ST_IDLE;
`ifdef VGA_ARB_CLEAR_EN
                ST_CLEAR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_vga_we <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_vga_addr <= r_clr_cnt + 1'b1;
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase

            if (w_done) begin
                if (r_owner == REQ_1) begin
                    r_ack1 <= 1'b1;
                    if (!r_we_own) r_rd1 <= vga_rd;
                end else begin
                    r_ack0 <= 1'b1;
                    if (!r_we_own) r_rd0 <= vga_rd;
                end
            end
        end
    end

    assign r0_ack   = r_ack0;
    assign r1_ack   = r_ack1;
    assign r0_rd    = r_rd0;
    assign r1_rd    = r_rd1;
    assign vga_we   = r_vga_we;
    assign vga_addr = r_vga_addr;
    assign vga_wd   = r_vga_wd;

endmodule

// File: doc/vga_port_arbiter.md
Name: vga_port_arbiter

Overview:
- Shares the single read/write port of the VGA text card between two requesters, e.g. the game FSM and a score/status writer.
- Round-robin, one access at a time, with a req/ack handshake per requester.
- Optional built-in screen-clear sequencer that temporarily owns the port.
- Sits between the requesters and the text card in the VGA test top level.

Parameters:
- ADDR_W, 12, card address width.
- DATA_W, 16, card data width (character + attribute word).
- CELLS, 2400, number of text cells written by a clear (80x30).
- CLEAR_WORD, 16'h0020, word written to every cell during a clear.
- RD_LAT, 0, extra cycles after the address cycle before vga_rd is valid (0 or 1 only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- r0_req  in  1  requester 0 access request; held until r0_ack.
- r0_we  in  1  1 = write, 0 = read; stable while r0_req.
- r0_addr  in  ADDR_W  cell address; stable while r0_req.
- r0_wd  in  DATA_W  write data; stable while r0_req.
- r0_ack  out  1  one-cycle completion pulse.
- r0_rd  out  DATA_W  read data; valid in the r0_ack cycle, held afterwards.
- r1_req, r1_we, r1_addr, r1_wd, r1_ack, r1_rd: same as the r0_* ports, for requester 1.
- clr_start  in  1  one-cycle clear request.
- clr_busy  out  1  clear pending or in progress.
- vga_we  out  1  card write enable.
- vga_addr  out  ADDR_W  card address.
- vga_wd  out  DATA_W  card write data.
- vga_rd  in  DATA_W  card read data.

Behaviour:
- Reset (rst low, async):
  - state = IDLE, round-robin pointer = 0, clear pending = 0, clear counter = 0.
  - All outputs 0.
  - An in-flight access is dropped with no ack.
- States: IDLE, ISSUE, RWAIT, ACK, CLEAR.
- IDLE, priority order:
  - If clear pending: go to CLEAR.
  - Else if exactly one req is high: grant it.
  - Else if both are high: grant the requester selected by the pointer, then point the pointer at the other requester.
  - On grant: register the owner and latch we/addr/wd into vga_addr/vga_wd; go to ISSUE.
  - A lone requester wins regardless of the pointer; the pointer then points away from the winner.
- ISSUE, one cycle:
  - vga_addr and vga_wd are driven; vga_we = owner's we.
  - Write: go to ACK.
  - Read with RD_LAT=0: capture vga_rd at the end of this cycle, go to ACK.
  - Read with RD_LAT=1: go to RWAIT.
- RWAIT: capture vga_rd at the end of this cycle; go to ACK.
- ACK:
  - Owner's ack = 1 for exactly one cycle; the owner's rd register is updated for reads.
  - Go to IDLE.
  - The requester must drop req in the ack cycle; if req is still high in IDLE it is treated as a new request.
- Latency from req sampled in IDLE at cycle T:
  - Write: vga_we at T+1, ack at T+2.
  - Read: ack at T+2+RD_LAT.
- vga_we is 1 only in ISSUE for writes and in CLEAR; 0 otherwise. vga_addr/vga_wd hold their last values when idle.
- Dropping req before ack is a protocol violation; behaviour is undefined and the bench does not test it. Addresses >= CELLS from requesters pass through unchanged.
- Simultaneous req from both requesters plus a pending clear: the clear wins; requests wait with no ack.

Optional Feature:
- Macro VGA_ARB_CLEAR_EN.
- When defined:
  - clr_start in any state sets clear pending and clr_busy = 1 on the next cycle.
  - The clear is taken at the next IDLE.
  - CLEAR writes addresses 0..CELLS-1, one per cycle: vga_we = 1, vga_wd = CLEAR_WORD.
  - After writing CELLS-1: clr_busy = 0, counter = 0, state = IDLE.
  - clr_start while clr_busy is ignored.
- When undefined: no CLEAR state, clr_start ignored, clr_busy tied 0.

Decomposition:
- Package vga_arb_pkg:
  - State enum.
  - Default ADDR_W/DATA_W/CELLS/CLEAR_WORD constants.
  - Requester index constants.
- Sub-module rr_arbiter2:
  - Combinational two-way pick from req and pointer.
  - Registered pointer with an advance input.

Test Plan:
- Write: r0 write addr 12'h005, wd 16'h0741, req at cycle T -> vga_we=1 with addr 005 at T+1; r0_ack at T+2; r1_ack stays 0.
- Read with RD_LAT=0: r1 read addr 12'h010, card returns 16'hBEEF -> r1_ack at T+2 with r1_rd=16'hBEEF; vga_we stays 0 throughout.
- Contention: both req held for 4 accesses each -> grants alternate r0,r1,r0,r1…; no requester is granted twice in a row while the other waits.
- Clear (VGA_ARB_CLEAR_EN defined): clr_start during an r0 access -> r0 access completes with ack; then 2400 consecutive vga_we cycles, addr 0..2399, wd 16'h0020; r1_req raised mid-clear is acked only after clr_busy falls.
- Reset mid-read (RD_LAT=1): rst low in RWAIT -> all outputs 0 immediately, no ack; after release, the first grant with both req high goes to r0.
- Clear compiled out: clr_start pulses -> clr_busy stays 0; no vga_we activity.
